// File: rtl/txrx_slot_ctrl_pkg.sv
// Shared baseband definitions for the TX/RX slot controller: FSM state
// encoding, legal packet occupancies and the default sync-search window.
package txrx_slot_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX      = 3'd1,
        ST_RX_SRCH = 3'd2,
        ST_RX_BUSY = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam logic [2:0] SLOTS_1 = 3'd1;
    localparam logic [2:0] SLOTS_3 = 3'd3;
    localparam logic [2:0] SLOTS_5 = 3'd5;

    localparam logic [9:0] DEFAULT_RX_WIN_US = 10'd20;
    localparam logic [2:0] DEFAULT_MAX_SLOTS = SLOTS_5;

    // Anything other than a 3- or 5-slot packet is handled as a single slot.
    function automatic logic [2:0] legal_slots(input logic [2:0] slots);
        return ((slots == SLOTS_3) || (slots == SLOTS_5)) ? slots : SLOTS_1;
    endfunction

endpackage

// File: rtl/txrx_slot_ctrl_if.sv
// Bundle of the slot timing, scheduler and radio-control signals between
// the baseband core (master side) and the slot controller (slave side).
interface txrx_slot_ctrl_if;

    logic        p_1us;
    logic        tslot_p;
    logic [27:0] BTCLK;
    logic [9:0]  counter_1us;
    logic        corre_sync_p;
    logic        regi_en;
    logic        regi_is_master;
    logic        tx_req;
    logic [2:0]  tx_slots;
    logic        tx_done_p;
    logic        rx_done_p;

    logic        tx_en;
    logic        rx_en;
    logic        tx_start_p;
    logic        rx_timeout_p;
    logic        tx_abort_p;
    logic [2:0]  state_o;

    modport master (
        output p_1us, tslot_p, BTCLK, counter_1us, corre_sync_p, regi_en,
               regi_is_master, tx_req, tx_slots, tx_done_p, rx_done_p,
        input  tx_en, rx_en, tx_start_p, rx_timeout_p, tx_abort_p, state_o
    );

    modport slave (
        input  p_1us, tslot_p, BTCLK, counter_1us, corre_sync_p, regi_en,
               regi_is_master, tx_req, tx_slots, tx_done_p, rx_done_p,
        output tx_en, rx_en, tx_start_p, rx_timeout_p, tx_abort_p, state_o
    );

endinterface

// File: rtl/txrx_slot_ctrl_slot_cnt.sv
// 3-bit load/decrement slot counter with a zero flag. It holds the number
// of slot boundaries still to be crossed before the final one of a packet.
module txrx_slot_ctrl_slot_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] count_reg;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 3'd0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != 3'd0)) begin
            count_reg <= count_reg - 3'd1;
        end
    end

    assign zero = (count_reg == 3'd0);

endmodule

// File: rtl/txrx_slot_ctrl.sv
// Slot-level TX/RX scheduler: picks TX or RX at each slot boundary from the
// role and slot parity, tracks multi-slot packets, times out the sync search
// and drives the radio enables.
module txrx_slot_ctrl
    import txrx_slot_ctrl_pkg::*;
#(
    parameter logic [9:0] RX_WIN_US = DEFAULT_RX_WIN_US,
    parameter logic [2:0] MAX_SLOTS = DEFAULT_MAX_SLOTS
) (
    input  logic             clk_6M,
    input  logic             rstz,
    txrx_slot_ctrl_if.slave  bus
);

    state_t     state_reg;
    state_t     state_next;
    logic       tx_start_reg;
    logic       cnt_load;
    logic [2:0] cnt_load_val;
    logic       cnt_dec;
    logic       cnt_zero;
    logic       tx_abort;
    logic       rx_timeout;
    logic       tx_parity;
    logic       sync_in_window;
    logic       unused_btclk;

    // BTCLK[1] still shows the old slot in the boundary cycle, so its value
    // there is the parity of the slot about to start (1 = even). Master
    // transmits in even slots, slave in odd ones.
    assign tx_parity      = (bus.BTCLK[1] == bus.regi_is_master);
    assign sync_in_window = bus.corre_sync_p && (bus.counter_1us <= RX_WIN_US);
    assign unused_btclk   = ^{bus.BTCLK[27:2], bus.BTCLK[0]};

    txrx_slot_ctrl_slot_cnt u_slot_cnt (
        .clk      (clk_6M),
        .rst_n    (rstz),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register plus the registered start pulse for the packet builder.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_reg    <= ST_IDLE;
            tx_start_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_start_reg <= (state_next == ST_TX) && (state_reg != ST_TX);
        end
    end

    // Next-state, slot counter control and the abort/timeout pulses.
    always_comb begin
        state_next   = state_reg;
        cnt_load     = 1'b0;
        cnt_load_val = 3'd0;
        cnt_dec      = 1'b0;
        tx_abort     = 1'b0;
        rx_timeout   = 1'b0;
        case (state_reg)
            // HOLD schedules at the boundary exactly like IDLE, so back-to-back
            // slots need no idle cycle in between.
            ST_IDLE, ST_HOLD: begin
                if (!bus.regi_en) begin
                    state_next = ST_IDLE;
                end else if (bus.tslot_p) begin
                    if (tx_parity && bus.tx_req) begin
                        state_next   = ST_TX;
                        cnt_load     = 1'b1;
                        cnt_load_val = legal_slots(bus.tx_slots) - 3'd1;
                    end else begin
                        state_next = ST_RX_SRCH;
                    end
                end
            end
            ST_TX: begin
                // A done pulse on the boundary wins over the slot limit.
                if (bus.tx_done_p) begin
                    state_next = ST_HOLD;
                end else if (bus.tslot_p) begin
                    if (cnt_zero) begin
                        tx_abort   = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ST_RX_SRCH: begin
                // A sync hit in the last window microsecond wins over the timeout.
                if (sync_in_window) begin
                    state_next   = ST_RX_BUSY;
                    cnt_load     = 1'b1;
                    cnt_load_val = MAX_SLOTS - 3'd1;
                end else if (bus.p_1us && (bus.counter_1us == RX_WIN_US)) begin
                    rx_timeout = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_RX_BUSY: begin
                if (bus.rx_done_p) begin
                    state_next = ST_HOLD;
                end else if (bus.tslot_p) begin
                    if (cnt_zero) begin
                        state_next = ST_HOLD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.tx_en        = (state_reg == ST_TX);
    assign bus.rx_en        = (state_reg == ST_RX_SRCH) || (state_reg == ST_RX_BUSY);
    assign bus.tx_start_p   = tx_start_reg;
    assign bus.tx_abort_p   = tx_abort;
    assign bus.rx_timeout_p = rx_timeout;
    assign bus.state_o      = state_reg;

endmodule
